// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared record type and constants for the write-back commit queue
package wb_pkg;

    localparam int WB_DATA_W     = 32;
    localparam int WB_ADDR_W     = 5;
    localparam int WB_CP0_ADDR_W = 5;
    localparam int WB_PC_W       = 32;

    localparam logic [WB_DATA_W-1:0] ZEROWORD     = '0;
    localparam logic [WB_ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef struct packed {
        logic [WB_PC_W-1:0]       pc;
        logic                     reg_we;
        logic [WB_ADDR_W-1:0]     reg_addr;
        logic [WB_DATA_W-1:0]     reg_data;
        logic                     hilo_we;
        logic [WB_DATA_W-1:0]     hi;
        logic [WB_DATA_W-1:0]     lo;
        logic                     cp0_we;
        logic [WB_CP0_ADDR_W-1:0] cp0_addr;
        logic [WB_DATA_W-1:0]     cp0_data;
        logic                     llbit_we;
        logic                     llbit;
    } wb_rec_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// rtl/wb_entry_fifo.sv - in-order record storage with extra-bit pointers
module wb_entry_fifo #(
    parameter int REC_W = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [REC_W-1:0] wr_data,
    output logic [REC_W-1:0] rd_data,
    output logic [REC_W-1:0] entries [DEPTH],
    output logic [PW-1:0]    wr_idx,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [REC_W-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Storage carries no reset; validity is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[PW-1:0]];
    assign entries = mem;
    assign wr_idx  = wr_ptr[PW-1:0];
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - buffered write-back commit stage with GPR forwarding lookup
module wb_commit_queue
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int CP0_ADDR_W = 5,
    parameter int PC_W       = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         in_pc,
    input  logic                    in_reg_we,
    input  logic [ADDR_W-1:0]       in_reg_addr,
    input  logic [DATA_W-1:0]       in_reg_data,
    input  logic                    in_hilo_we,
    input  logic [DATA_W-1:0]       in_hi,
    input  logic [DATA_W-1:0]       in_lo,
    input  logic                    in_cp0_we,
    input  logic [CP0_ADDR_W-1:0]   in_cp0_addr,
    input  logic [DATA_W-1:0]       in_cp0_data,
    input  logic                    in_llbit_we,
    input  logic                    in_llbit,
    input  logic                    stall_req_from_arbiter,
    output logic [PC_W-1:0]         wb_pc_o,
    output logic                    wb_reg_write_en_o,
    output logic [ADDR_W-1:0]       wb_reg_write_addr_o,
    output logic [DATA_W-1:0]       wb_reg_write_data_o,
    output logic                    wb_hilo_write_en_o,
    output logic [DATA_W-1:0]       wb_hi_write_data_o,
    output logic [DATA_W-1:0]       wb_lo_write_data_o,
    output logic                    wb_cp0_reg_write_en_o,
    output logic [CP0_ADDR_W-1:0]   wb_cp0_reg_write_addr_o,
    output logic [DATA_W-1:0]       wb_cp0_reg_write_data_o,
    output logic                    wb_LLbit_write_en_o,
    output logic                    wb_LLbit_data_o,
    input  logic [ADDR_W-1:0]       fwd_addr,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW    = $clog2(DEPTH);
    localparam int REC_W = $bits(wb_rec_t);

    wb_rec_t          rec_in;
    wb_rec_t          head;
    wb_rec_t          ent;
    logic [REC_W-1:0] rd_data;
    logic [REC_W-1:0] entries [DEPTH];
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    idx;
    logic [PW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // in_ready depends only on occupancy, never on the stall input.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !stall_req_from_arbiter;
    assign count_o  = count;

    always_comb begin
        rec_in          = '0;
        rec_in.pc       = in_pc;
        rec_in.reg_we   = in_reg_we && (in_reg_addr != NOP_REG_ADDR);
        rec_in.reg_addr = in_reg_addr;
        rec_in.reg_data = in_reg_data;
        rec_in.hilo_we  = in_hilo_we;
        rec_in.hi       = in_hi;
        rec_in.lo       = in_lo;
        rec_in.cp0_we   = in_cp0_we;
        rec_in.cp0_addr = in_cp0_addr;
        rec_in.cp0_data = in_cp0_data;
        rec_in.llbit_we = in_llbit_we;
        rec_in.llbit    = in_llbit;
    end

    wb_entry_fifo #(
        .REC_W (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push),
        .pop     (pop),
        .wr_data (rec_in),
        .rd_data (rd_data),
        .entries (entries),
        .wr_idx  (wr_idx),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        head = '0;
        if (!empty) head = rd_data;
    end

    assign wb_pc_o                 = head.pc;
    assign wb_reg_write_en_o       = head.reg_we && pop;
    assign wb_reg_write_addr_o     = head.reg_addr;
    assign wb_reg_write_data_o     = head.reg_data;
    assign wb_hilo_write_en_o      = head.hilo_we && pop;
    assign wb_hi_write_data_o      = head.hi;
    assign wb_lo_write_data_o      = head.lo;
    assign wb_cp0_reg_write_en_o   = head.cp0_we && pop;
    assign wb_cp0_reg_write_addr_o = head.cp0_addr;
    assign wb_cp0_reg_write_data_o = head.cp0_data;
    assign wb_LLbit_write_en_o     = head.llbit_we && pop;
    assign wb_LLbit_data_o         = head.llbit;

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = ZEROWORD;
        idx      = '0;
        ent      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = wr_idx - PW'(i) - PW'(1);
            ent = entries[idx];
            if (((PW+1)'(i) < count) && ent.reg_we && (ent.reg_addr == fwd_addr)
                && (fwd_addr != NOP_REG_ADDR)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent.reg_data;
            end
        end
    end

endmodule
